// File: rtl/alu_cmd_driver_if.sv
// alu_cmd_driver_if: bundles the command stream, ALU operand/result bus and
// response stream of alu_cmd_driver.
//   cmd_*   : command stream into the driver (valid/ready) plus FIFO occupancy
//   alu_*   : registered operands out to an external combinational alu,
//             result/flags back from it
//   rsp_*   : captured result stream out of the driver (valid/ready)
// Modports: slave = the driver itself, master = the surrounding environment.
interface alu_cmd_driver_if #(
    parameter int unsigned N     = 8,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          cmd_valid;
    logic          cmd_ready;
    logic [N-1:0]  cmd_a;
    logic [N-1:0]  cmd_b;
    logic [3:0]    cmd_op;
    logic          cmd_acc;
    logic [CW-1:0] cmd_count;

    logic [N-1:0]  alu_a;
    logic [N-1:0]  alu_b;
    logic [3:0]    alu_op;
    logic [N-1:0]  alu_y;
    logic          alu_z;
    logic          alu_c;
    logic          alu_nf;
    logic          alu_v;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [N-1:0]  rsp_y;
    logic [3:0]    rsp_flags;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_acc,
        output cmd_ready, cmd_count,
        output alu_a, alu_b, alu_op,
        input  alu_y, alu_z, alu_c, alu_nf, alu_v,
        output rsp_valid, rsp_y, rsp_flags,
        input  rsp_ready
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_acc,
        input  cmd_ready, cmd_count,
        input  alu_a, alu_b, alu_op,
        output alu_y, alu_z, alu_c, alu_nf, alu_v,
        input  rsp_valid, rsp_y, rsp_flags,
        output rsp_ready
    );
endinterface

// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: issuing end of the ALU operand interface. Buffers commands
// in a DEPTH-entry FIFO, presents one command at a time as registered
// A/B/opcode to an external combinational alu, captures Y and {Z,C,Nf,V}
// one cycle later and returns them on a valid/ready response stream.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : alu_cmd_driver_if.slave (cmd_*, alu_*, rsp_*, cmd_count)
// Optional build macro ALU_DRV_ACC_CHAIN_EN: keeps an accumulator of the last
// captured Y and substitutes it for operand A on commands flagged cmd_acc.
module alu_cmd_driver #(
    parameter int unsigned N     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_cmd_driver_if.slave     bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
`ifdef ALU_DRV_ACC_CHAIN_EN
    localparam int unsigned EW = 2 * N + 5;
`else
    localparam int unsigned EW = 2 * N + 4;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t         state;
    logic [EW-1:0]  mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [N-1:0]   alu_a_q;
    logic [N-1:0]   alu_b_q;
    logic [3:0]     alu_op_q;
    logic           rsp_valid_q;
    logic [N-1:0]   rsp_y_q;
    logic [3:0]     rsp_flags_q;
`ifdef ALU_DRV_ACC_CHAIN_EN
    logic [N-1:0]   acc_q;
`endif

    logic           not_full_c;
    logic           non_empty_c;
    logic           push_c;
    logic           pop_c;
    logic [EW-1:0]  wr_entry_c;
    logic [EW-1:0]  head_c;
    logic [N-1:0]   head_a_c;

    // FIFO flow control, derived from registered occupancy only
    assign not_full_c  = (count != CW'(DEPTH));
    assign non_empty_c = (count != CW'(0));
    assign push_c      = bus.cmd_valid && not_full_c;
    assign pop_c       = non_empty_c &&
                         ((state == IDLE) || ((state == RESP) && bus.rsp_ready));

    // FIFO entry layout: {[acc,] op, b, a}
`ifdef ALU_DRV_ACC_CHAIN_EN
    assign wr_entry_c = {bus.cmd_acc, bus.cmd_op, bus.cmd_b, bus.cmd_a};
`else
    assign wr_entry_c = {bus.cmd_op, bus.cmd_b, bus.cmd_a};
    logic unused_cmd_acc;
    assign unused_cmd_acc = bus.cmd_acc;
`endif

    assign head_c = mem[rd_ptr];

    // operand A for the next load, optionally chained from the previous result
`ifdef ALU_DRV_ACC_CHAIN_EN
    assign head_a_c = head_c[2*N+4] ? acc_q : head_c[N-1:0];
`else
    assign head_a_c = head_c[N-1:0];
`endif

    // FIFO storage, no reset needed: occupancy tracking masks stale entries
    always_ff @(posedge clk) begin
        if (rst_n && push_c) begin
            mem[wr_ptr] <= wr_entry_c;
        end
    end

    // FIFO pointers/occupancy and the issue/capture FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            state       <= IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_y_q     <= '0;
            rsp_flags_q <= '0;
`ifdef ALU_DRV_ACC_CHAIN_EN
            acc_q       <= '0;
`endif
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            case (state)
                IDLE: begin
                    if (non_empty_c) begin
                        alu_a_q  <= head_a_c;
                        alu_b_q  <= head_c[2*N-1:N];
                        alu_op_q <= head_c[2*N+3:2*N];
                        state    <= DRIVE;
                    end
                end
                DRIVE: begin
                    rsp_y_q     <= bus.alu_y;
                    rsp_flags_q <= {bus.alu_z, bus.alu_c, bus.alu_nf, bus.alu_v};
                    rsp_valid_q <= 1'b1;
`ifdef ALU_DRV_ACC_CHAIN_EN
                    acc_q       <= bus.alu_y;
`endif
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (non_empty_c) begin
                            alu_a_q  <= head_a_c;
                            alu_b_q  <= head_c[2*N-1:N];
                            alu_op_q <= head_c[2*N+3:2*N];
                            state    <= DRIVE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = not_full_c;
    assign bus.cmd_count = count;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_y     = rsp_y_q;
    assign bus.rsp_flags = rsp_flags_q;
endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb_alu_cmd_driver: directed + randomized bench for alu_cmd_driver with a
// behavioural alu and a queue-based reference of the expected response stream.
module tb_alu_cmd_driver;
    localparam int unsigned N     = 8;
    localparam int unsigned DEPTH = 4;
`ifdef ALU_DRV_ACC_CHAIN_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        logic       acc;
    } cmd_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    cmd_t q[$];
    logic [7:0] model_acc;
    logic [11:0] alu_r;

    alu_cmd_driver_if #(.N(N), .DEPTH(DEPTH)) bus ();

    alu_cmd_driver #(.N(N), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural alu: returns {Y, Z, C, Nf, V}
    function automatic logic [11:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] op);
        logic [8:0] t;
        logic [7:0] y;
        logic       c;
        logic       v;
        t = 9'd0; c = 1'b0; v = 1'b0;
        case (op)
            4'd0: begin t = {1'b0, a} + {1'b0, b}; y = t[7:0]; c = t[8];
                        v = (a[7] == b[7]) && (y[7] != a[7]); end
            4'd1: begin t = {1'b0, a} - {1'b0, b}; y = t[7:0]; c = t[8];
                        v = (a[7] != b[7]) && (y[7] != a[7]); end
            4'd2: y = a & b;
            4'd3: y = a | b;
            4'd4: y = a ^ b;
            4'd5: y = ~a;
            4'd6: begin y = {1'b0, a[7:1]}; c = a[0]; end
            4'd8: begin y = {a[6:0], 1'b0}; c = a[7]; v = a[7] ^ a[6]; end
            default: y = b;
        endcase
        return {y, (y == 8'd0), c, y[7], v};
    endfunction

    always_comb alu_r = alu_fn(bus.alu_a, bus.alu_b, bus.alu_op);
    assign bus.alu_y  = alu_r[11:4];
    assign bus.alu_z  = alu_r[3];
    assign bus.alu_c  = alu_r[2];
    assign bus.alu_nf = alu_r[1];
    assign bus.alu_v  = alu_r[0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // compare a response being consumed at the coming edge against the model
    task automatic check_rsp();
        cmd_t        c;
        logic [7:0]  a_eff;
        logic [11:0] r;
        if (q.size() == 0) begin
            chk("rsp_unexpected", 32'(bus.rsp_valid), 32'(0));
        end else begin
            c     = q.pop_front();
            a_eff = (ACC && c.acc) ? model_acc : c.a;
            r     = alu_fn(a_eff, c.b, c.op);
            chk("rsp_y", 32'(bus.rsp_y), 32'(r[11:4]));
            chk("rsp_flags", 32'(bus.rsp_flags), 32'(r[3:0]));
            model_acc = r[11:4];
        end
    endtask

    // one clock with handshake bookkeeping for the edge about to happen
    task automatic cycle();
        if (bus.rsp_valid && bus.rsp_ready) check_rsp();
        if (bus.cmd_valid && bus.cmd_ready)
            q.push_back('{a: bus.cmd_a, b: bus.cmd_b, op: bus.cmd_op, acc: bus.cmd_acc});
        tick();
    endtask

    task automatic do_reset(input int cycles, input logic valid_during);
        rst_n = 1'b0;
        bus.cmd_valid = valid_during;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < cycles; i++) tick();
        q.delete();
        model_acc = 8'd0;
        rst_n = 1'b1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic push_cmd(input logic [7:0] a, input logic [7:0] b,
                            input logic [3:0] op, input logic acc);
        bit done;
        done = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_a = a; bus.cmd_b = b; bus.cmd_op = op; bus.cmd_acc = acc;
        for (int i = 0; i < 50 && !done; i++) begin
            done = bus.cmd_ready;
            cycle();
        end
        bus.cmd_valid = 1'b0;
        chk("push_accepted", 32'(done), 32'(1));
    endtask

    task automatic wait_rsp(input string tag);
        for (int i = 0; i < 20 && !bus.rsp_valid; i++) cycle();
        chk(tag, 32'(bus.rsp_valid), 32'(1));
    endtask

    task automatic drain();
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 200 && q.size() != 0; i++) cycle();
        chk("drain_empty", 32'(q.size()), 32'(0));
        chk("drain_idle", 32'(bus.rsp_valid), 32'(0));
    endtask

    initial begin
        logic [7:0] y0;
        logic [3:0] f0;
        checks = 0; errors = 0; model_acc = 8'd0;
        bus.cmd_a = 8'd0; bus.cmd_b = 8'd0; bus.cmd_op = 4'd0; bus.cmd_acc = 1'b0;
        bus.rsp_ready = 1'b0;

        // reset held two cycles with cmd_valid asserted
        do_reset(2, 1'b1);
        chk("rst_count", 32'(bus.cmd_count), 32'(0));
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
        chk("rst_alu_a", 32'(bus.alu_a), 32'(0));
        chk("rst_alu_b", 32'(bus.alu_b), 32'(0));
        chk("rst_alu_op", 32'(bus.alu_op), 32'(0));
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'(1));

        // single op latency: push at e0, operands after e1, response after e2
        bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b1; bus.cmd_a = 8'd5; bus.cmd_b = 8'd2; bus.cmd_op = 4'd0;
        bus.cmd_acc = 1'b0;
        cycle();
        bus.cmd_valid = 1'b0;
        chk("single_count_e0", 32'(bus.cmd_count), 32'(1));
        cycle();
        chk("single_alu_a", 32'(bus.alu_a), 32'(5));
        chk("single_alu_b", 32'(bus.alu_b), 32'(2));
        chk("single_alu_op", 32'(bus.alu_op), 32'(0));
        chk("single_no_rsp_e1", 32'(bus.rsp_valid), 32'(0));
        cycle();
        chk("single_rsp_valid_e2", 32'(bus.rsp_valid), 32'(1));
        chk("single_rsp_y_const", 32'(bus.rsp_y), 32'(7));
        chk("single_rsp_flags_const", 32'(bus.rsp_flags), 32'(0));
        drain();

        // back-pressure until full, then ordered drain
        bus.rsp_ready = 1'b0;
        for (int k = 1; k <= 5; k++)
            push_cmd(8'($urandom), 8'($urandom), 4'(k), 1'b0);
        cycle(); cycle();
        chk("full_count", 32'(bus.cmd_count), 32'(4));
        chk("full_cmd_ready", 32'(bus.cmd_ready), 32'(0));
        chk("full_rsp_valid", 32'(bus.rsp_valid), 32'(1));
        chk("full_alu_op_first", 32'(bus.alu_op), 32'(1));
        y0 = bus.rsp_y; f0 = bus.rsp_flags;
        for (int i = 0; i < 10; i++) cycle();
        chk("stall_rsp_y", 32'(bus.rsp_y), 32'(y0));
        chk("stall_rsp_flags", 32'(bus.rsp_flags), 32'(f0));
        chk("stall_rsp_valid", 32'(bus.rsp_valid), 32'(1));
        chk("stall_count", 32'(bus.cmd_count), 32'(4));
        drain();

        // flags on a shift that sets Z, C and V
        bus.rsp_ready = 1'b0;
        push_cmd(8'h80, 8'h01, 4'b1000, 1'b0);
        wait_rsp("flags_wait");
        chk("flags_value", 32'(bus.rsp_flags), 32'(4'b1101));
        chk("flags_y", 32'(bus.rsp_y), 32'(0));
        for (int i = 0; i < 3; i++) cycle();
        chk("flags_held", 32'(bus.rsp_flags), 32'(4'b1101));
        drain();

        // reset mid-operation discards queue and pending response
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++)
            push_cmd(8'($urandom), 8'($urandom), 4'($urandom), 1'b0);
        wait_rsp("midrst_wait");
        chk("midrst_count_before", 32'(bus.cmd_count), 32'(3));
        do_reset(1, 1'b0);
        chk("midrst_count", 32'(bus.cmd_count), 32'(0));
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("midrst_quiet", 32'(bus.rsp_valid), 32'(0));
        end

`ifdef ALU_DRV_ACC_CHAIN_EN
        // accumulator chaining: second command takes A from first result
        bus.rsp_ready = 1'b0;
        push_cmd(8'd5, 8'd2, 4'd0, 1'b0);
        push_cmd(8'd99, 8'd3, 4'd0, 1'b1);
        wait_rsp("acc_wait");
        bus.rsp_ready = 1'b1;
        cycle();
        chk("acc_alu_a", 32'(bus.alu_a), 32'(7));
        drain();
`endif

        // randomized traffic with random back-pressure
        for (int i = 0; i < 400; i++) begin
            bus.cmd_valid = 1'($urandom_range(0, 1));
            bus.cmd_a     = 8'($urandom);
            bus.cmd_b     = 8'($urandom);
            bus.cmd_op    = 4'($urandom);
            bus.cmd_acc   = 1'($urandom_range(0, 1));
            bus.rsp_ready = 1'($urandom_range(0, 1));
            cycle();
            chk("rand_count_le_depth", 32'(bus.cmd_count <= 3'(DEPTH)), 32'(1));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_cmd_driver.md
Name: alu_cmd_driver

Overview:
- Initiator/issuing end of the ALU operand interface: accepts ALU commands on a valid/ready stream and buffers them in a small FIFO.
- Drives registered A/B/opcode into an external combinational `alu` instance, one command at a time.
- Captures Y and the Z/C/Nf/V flags and returns them on a valid/ready response stream.
- Sits between a sequencer/CPU-style front end and the existing ALU.

Parameters:
- N, 8, operand/result width; must match the attached `alu` N.
- DEPTH, 4, command FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO not full.
- cmd_a  input  N  operand A.
- cmd_b  input  N  operand B.
- cmd_op  input  4  ALU opcode, passed through unmodified.
- cmd_acc  input  1  use previous result as A; only meaningful with ALU_DRV_ACC_CHAIN_EN.
- alu_a  output  N  to alu.A, registered.
- alu_b  output  N  to alu.B, registered.
- alu_op  output  4  to alu.opcode, registered.
- alu_y  input  N  from alu.Y.
- alu_z, alu_c, alu_nf, alu_v  input  1 each  from alu Z, C, Nf, V.
- rsp_valid  output  1  response held.
- rsp_ready  input  1  consumer accepts.
- rsp_y  output  N  captured Y.
- rsp_flags  output  4  captured flags as {Z, C, Nf, V}.
- cmd_count  output  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst_n=0 at an edge): FIFO emptied, cmd_count=0, state=IDLE, alu_a=alu_b=0, alu_op=0, rsp_valid=0, rsp_y=0, rsp_flags=0, accumulator=0. Reset mid-operation drops the queued commands and any pending response.
- cmd_ready = (cmd_count != DEPTH), combinational from state only.
- A push occurs when cmd_valid && cmd_ready. The FIFO is written at that edge.
- A pop occurs on the IDLE->DRIVE or RESP->DRIVE transition.
- Simultaneous push and pop when the FIFO is full is not possible, because cmd_ready=0. When partially full, cmd_count is unchanged.
- Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if cmd_count>0, load the head into alu_a/alu_b/alu_op, pop, and go to DRIVE. Otherwise hold.
  - DRIVE (exactly 1 cycle): the ALU settles combinationally. At the next edge, rsp_y<=alu_y, rsp_flags<={alu_z,alu_c,alu_nf,alu_v}, rsp_valid<=1, state<=RESP.
  - RESP: rsp_* remain stable while rsp_valid && !rsp_ready. On rsp_ready:
    - if the FIFO is non-empty, load and pop the next head and go to DRIVE, with rsp_valid<=0;
    - else rsp_valid<=0 and go to IDLE.
- alu_a/alu_b/alu_op hold their last value outside DRIVE; they are not zeroed.
- Latency: command accepted at edge e0 into an empty FIFO in IDLE -> operands driven after e1 -> rsp_valid=1 after e2.
- Throughput: 1 result per 2 cycles with rsp_ready tied high.
- Ordering is strict FIFO; no command is dropped or reordered.
- A push in the same cycle as the IDLE check does not bypass the FIFO; it is seen one cycle later.

Optional Feature:
- Macro ALU_DRV_ACC_CHAIN_EN.
- Defined:
  - an internal N-bit accumulator is updated with alu_y on every DRIVE->RESP capture;
  - on load, if the head's cmd_acc=1, alu_a<=accumulator instead of the stored cmd_a;
  - cmd_acc is stored in the FIFO (width N*2+5).
- Undefined:
  - cmd_acc is ignored and not stored (width N*2+4);
  - there is no accumulator register.

Test Plan:
- Reset: rst_n=0 for 2 cycles with cmd_valid=1 -> cmd_count=0, rsp_valid=0, alu_a=alu_b=alu_op=0 after release.
- Single op: push A=5, B=2, op=0 at edge e0, rsp_ready=1 -> alu_a=5, alu_b=2 after e1; rsp_valid=1 after e2 with rsp_y/rsp_flags equal to the alu outputs for (5,2,op0).
- Back-pressure and full: rsp_ready=0, push 5 commands (op 1..5) -> first goes to DRIVE/RESP, then 4 queued; cmd_ready=0 with cmd_count=4; rsp_y is stable for 10 cycles; releasing rsp_ready drains op1..op5 in order.
- Flags: push A=8'b1000_0000, B=1, op=4'b1000 -> rsp_flags equals {Z,C,Nf,V} as presented by the alu in DRIVE, held through RESP.
- Reset mid-operation: 3 queued commands with rsp_valid=1, assert rst_n=0 for one edge -> all queued commands are discarded, and no rsp_valid appears for 5 cycles after release.
- (ALU_DRV_ACC_CHAIN_EN) push {5,2,op0,acc=0} then {x,3,op0,acc=1} -> second command drives alu_a = first rsp_y.
